// File: rtl/fnn_ctrl_pkg.sv
// Shared types and constants for the FNN layer sequencing controller.
package fnn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_SPURIOUS = 1;

    // Counter width able to index 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_ctrl_if.sv
// Upstream vector, neuron broadcast/collect and downstream result signals.
interface layer_seq_ctrl_if #(
    parameter int unsigned numInputs  = 30,
    parameter int unsigned numNeurons = 10,
    parameter int unsigned dataWidth  = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [numInputs*dataWidth-1:0]  in_data;
    logic [dataWidth-1:0]            neuron_data;
    logic                            neuron_valid;
    logic [numNeurons-1:0]           neuron_outvalid;
    logic [numNeurons*dataWidth-1:0] neuron_out;
    logic                            out_valid;
    logic                            out_ready;
    logic [numNeurons*dataWidth-1:0] out_data;

    // Controller side.
    modport master (
        input  in_valid, in_data, neuron_outvalid, neuron_out, out_ready,
        output in_ready, neuron_data, neuron_valid, out_valid, out_data
    );

    // Environment side: upstream producer, neurons and downstream consumer.
    modport slave (
        output in_valid, in_data, neuron_outvalid, neuron_out, out_ready,
        input  in_ready, neuron_data, neuron_valid, out_valid, out_data
    );
endinterface

// File: rtl/neuron_result_collector.sv
// Per-lane done bits and capture registers for the neuron outputs of one frame.
module neuron_result_collector #(
    parameter int unsigned numNeurons = 10,
    parameter int unsigned dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            capture,
    input  logic [numNeurons-1:0]           outvalid,
    input  logic [numNeurons*dataWidth-1:0] lanes_in,
    output logic [numNeurons*dataWidth-1:0] lanes_out,
    output logic                            all_done_c
);
    logic [numNeurons-1:0] done_q;
    logic [numNeurons-1:0] hit_c;

    // Lanes completing this cycle; repeats on finished lanes are dropped.
    always_comb begin
        hit_c      = outvalid & ~done_q & {numNeurons{capture}};
        all_done_c = &(done_q | hit_c);
    end

    // Capture first result per lane; clear at the start of every frame.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            done_q    <= '0;
            lanes_out <= '0;
        end else begin
            for (int unsigned i = 0; i < numNeurons; i++) begin
                if (hit_c[i]) begin
                    lanes_out[i*dataWidth +: dataWidth] <= lanes_in[i*dataWidth +: dataWidth];
                end
            end
            done_q <= done_q | hit_c;
        end
    end
endmodule

// File: rtl/layer_seq_ctrl.sv
// Frame controller: serialize an input vector to a neuron layer, collect results.
module layer_seq_ctrl
    import fnn_ctrl_pkg::*;
#(
    parameter int unsigned numInputs     = 30,
    parameter int unsigned numNeurons    = 10,
    parameter int unsigned dataWidth     = 16,
    parameter int unsigned timeoutCycles = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_seq_ctrl_if.master        bus,
    output logic [1:0]              err,
    input  logic                    err_clr,
    output logic                    busy
);
    localparam int unsigned CNT_W = cnt_width(numInputs);
    localparam int unsigned TMR_W = cnt_width(timeoutCycles);
    localparam int unsigned VEC_W = numInputs * dataWidth;

    seq_state_t           state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [TMR_W-1:0]     tmr_q, tmr_n;
    logic [VEC_W-1:0]     buf_q, buf_n;
    logic [1:0]           err_n;
    logic [dataWidth-1:0] ndata_n;
    logic                 accept_c, capture_c, timeout_c, spurious_c, all_done_c;

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        tmr_n     = tmr_q;
        buf_n     = buf_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    buf_n    = bus.in_data;
                    cnt_n    = '0;
                    state_n  = STREAM;
                end
            end
            STREAM: begin
                if (cnt_q == CNT_W'(numInputs - 1)) begin
                    tmr_n   = '0;
                    state_n = WAIT;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                capture_c = 1'b1;
                if (all_done_c) begin
                    state_n = HOLD;
                end else if (tmr_q == TMR_W'(timeoutCycles - 1)) begin
                    timeout_c = 1'b1;
                    state_n   = HOLD;
                end else begin
                    tmr_n = tmr_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        spurious_c = (state_q != WAIT) && (|bus.neuron_outvalid);
        err_n      = err_clr ? 2'b00 : err;
        if (timeout_c)  err_n[ERR_TIMEOUT]  = 1'b1;
        if (spurious_c) err_n[ERR_SPURIOUS] = 1'b1;

        ndata_n = (state_n == STREAM) ? buf_n[cnt_n*dataWidth +: dataWidth] : '0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            tmr_q            <= '0;
            buf_q            <= '0;
            err              <= '0;
            busy             <= 1'b0;
            bus.in_ready     <= 1'b1;
            bus.neuron_valid <= 1'b0;
            bus.neuron_data  <= '0;
            bus.out_valid    <= 1'b0;
        end else begin
            state_q          <= state_n;
            cnt_q            <= cnt_n;
            tmr_q            <= tmr_n;
            buf_q            <= buf_n;
            err              <= err_n;
            busy             <= (state_n != IDLE);
            bus.in_ready     <= (state_n == IDLE);
            bus.neuron_valid <= (state_n == STREAM);
            bus.neuron_data  <= ndata_n;
            bus.out_valid    <= (state_n == HOLD);
        end
    end

    neuron_result_collector #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth)
    ) u_collector (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_c),
        .capture    (capture_c),
        .outvalid   (bus.neuron_outvalid),
        .lanes_in   (bus.neuron_out),
        .lanes_out  (bus.out_data),
        .all_done_c (all_done_c)
    );
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl (4 inputs, 3 neurons, 16-bit, timeout 8).
module tb_layer_seq_ctrl;
    localparam int unsigned NI = 4;
    localparam int unsigned NN = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;

    typedef struct packed {
        logic [NN*DW-1:0] data;
        logic [1:0]       err;
    } res_t;

    logic       clk;
    logic       rst;
    logic [1:0] err;
    logic       err_clr;
    logic       busy;

    layer_seq_ctrl_if #(.numInputs(NI), .numNeurons(NN), .dataWidth(DW)) bus ();

    layer_seq_ctrl #(
        .numInputs     (NI),
        .numNeurons    (NN),
        .dataWidth     (DW),
        .timeoutCycles (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .err     (err),
        .err_clr (err_clr),
        .busy    (busy)
    );

    logic [DW-1:0] exp_stream[$];
    res_t          exp_res[$];
    int            checks = 0;
    int            errors = 0;
    int            nv_count = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected stream elements and results as the DUT presents them.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        res_t          r;
        if (bus.neuron_valid === 1'b1) begin
            nv_count++;
            if (exp_stream.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra actual=%0h expected=none", bus.neuron_data);
            end else begin
                e = exp_stream.pop_front();
                chk("stream_data", 64'(bus.neuron_data), 64'(e));
            end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_extra actual=%0h expected=none", bus.out_data);
            end else begin
                r = exp_res.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(r.data));
                chk("err_at_out", 64'(err), 64'(r.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [NI*DW-1:0] v, input int n);
        for (int k = 0; k < n; k++) exp_stream.push_back(v[k*DW +: DW]);
    endtask

    // Present a vector for one accepting edge; returns #1 after that edge.
    task automatic send(input logic [NI*DW-1:0] v, input logic [NN*DW-1:0] e_out,
                        input logic [1:0] e_err);
        res_t r;
        push_stream(v, NI);
        r.data = e_out;
        r.err  = e_err;
        exp_res.push_back(r);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Drive neuron outvalid at given WAIT cycles (-1 = never); returns the cycle out_valid rose.
    task automatic respond(input int c0, input int c1, input int c2,
                           input logic [NN*DW-1:0] vals, output int fin);
        fin = -1;
        bus.neuron_out = vals;
        for (int c = 0; c < 2*TO; c++) begin
            bus.neuron_outvalid = {c2 == c, c1 == c, c0 == c};
            tick();
            bus.neuron_outvalid = '0;
            if (bus.out_valid) begin
                fin = c;
                break;
            end
        end
    endtask

    initial begin
        int fin;
        int nv0;
        rst = 1'b0;
        err_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.neuron_outvalid = '0;
        bus.neuron_out = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_neuron_valid", 64'(bus.neuron_valid), 64'(0));
        chk("rst_neuron_data", 64'(bus.neuron_data), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        tick();

        // Basic frame: lanes return on WAIT cycles 2, 5, 3.
        nv0 = nv_count;
        send({16'h0004, 16'h0003, 16'h0002, 16'h0001}, {16'h0C0C, 16'h0B0B, 16'h0A0A}, 2'b00);
        chk("basic_busy", 64'(busy), 64'(1));
        chk("basic_in_ready", 64'(bus.in_ready), 64'(0));
        repeat (NI) tick();
        chk("basic_wait_nv", 64'(bus.neuron_valid), 64'(0));
        respond(2, 5, 3, {16'h0C0C, 16'h0B0B, 16'h0A0A}, fin);
        chk("basic_done_cycle", 64'(fin), 64'(5));
        chk("basic_nv_len", 64'(nv_count - nv0), 64'(NI));
        tick();
        chk("basic_idle_ready", 64'(bus.in_ready), 64'(1));

        // Simultaneous completion on WAIT cycle 1.
        send({16'h1111, 16'h2222, 16'h3333, 16'h4444}, {16'h00C3, 16'h00B2, 16'h00A1}, 2'b00);
        repeat (NI) tick();
        respond(1, 1, 1, {16'h00C3, 16'h00B2, 16'h00A1}, fin);
        chk("simul_done_cycle", 64'(fin), 64'(1));
        tick();

        // Backpressure with a new vector pending.
        bus.out_ready = 1'b0;
        send({16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01}, {16'h5555, 16'h6666, 16'h7777}, 2'b00);
        repeat (NI) tick();
        respond(0, 0, 0, {16'h5555, 16'h6666, 16'h7777}, fin);
        chk("bp_done_cycle", 64'(fin), 64'(0));
        push_stream({16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01}, NI);
        bus.in_valid = 1'b1;
        bus.in_data = {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01};
        bus.neuron_out = {16'hDEAD, 16'hBEEF, 16'hF00D};
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_out_data", 64'(bus.out_data), 64'({16'h5555, 16'h6666, 16'h7777}));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(bus.out_valid), 64'(0));
        chk("bp_release_ready", 64'(bus.in_ready), 64'(1));
        exp_res.push_back('{data: {16'h0303, 16'h0202, 16'h0101}, err: 2'b00});
        tick();
        bus.in_valid = 1'b0;
        repeat (NI) tick();
        respond(0, 1, 2, {16'h0303, 16'h0202, 16'h0101}, fin);
        chk("bp_next_done", 64'(fin), 64'(2));
        tick();

        // Timeout: lane 2 never answers.
        send({16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01}, {16'h0000, 16'h2222, 16'h1111}, 2'b01);
        repeat (NI) tick();
        respond(1, 4, -1, {16'h3333, 16'h2222, 16'h1111}, fin);
        chk("timeout_cycle", 64'(fin), 64'(TO - 1));
        tick();
        chk("timeout_err_sticky", 64'(err), 64'(2'b01));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_err_clr", 64'(err), 64'(0));

        // Spurious outvalid on lane 1 during STREAM.
        send({16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1}, {16'h9C9C, 16'h9B9B, 16'h9A9A}, 2'b10);
        tick();
        bus.neuron_outvalid = 3'b010;
        bus.neuron_out = {16'hEEEE, 16'hEEEE, 16'hEEEE};
        tick();
        bus.neuron_outvalid = '0;
        chk("spur_err", 64'(err), 64'(2'b10));
        chk("spur_streaming", 64'(bus.neuron_valid), 64'(1));
        tick();
        tick();
        respond(0, 2, 1, {16'h9C9C, 16'h9B9B, 16'h9A9A}, fin);
        chk("spur_done_cycle", 64'(fin), 64'(2));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("spur_err_clr", 64'(err), 64'(0));

        // Reset in the middle of STREAM, then a fresh frame.
        push_stream({16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01}, 2);
        bus.in_valid = 1'b1;
        bus.in_data = {16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01};
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_nv", 64'(bus.neuron_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        send({16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01}, {16'h4242, 16'h4141, 16'h4040}, 2'b00);
        repeat (NI) tick();
        respond(3, 3, 0, {16'h4242, 16'h4141, 16'h4040}, fin);
        chk("post_rst_done", 64'(fin), 64'(3));
        tick();
        tick();

        chk("stream_queue_empty", 64'(exp_stream.size()), 64'(0));
        chk("result_queue_empty", 64'(exp_res.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
